// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - nested interrupt controller with fixed priority, preemption and return-PC stack
module interrupt_ctrl #(
    parameter int              WIDTH      = 32,
    parameter int              NUM_IRQ    = 3,
    parameter int              NEST_DEPTH = 3,
    parameter logic [WIDTH-1:0] VEC_BASE  = 32'h0000_0100,
    parameter int              VEC_STRIDE = 4,
    localparam int             LW         = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ecall,
    input  logic               uret,
    input  logic               stall,
    input  logic               csr_we,
    input  logic [1:0]         csr_op,
    input  logic [NUM_IRQ-1:0] csr_wdata,
    output logic [NUM_IRQ-1:0] csr_rdata,
    input  logic [WIDTH-1:0]   epc_in,
    output logic               take,
    output logic [WIDTH-1:0]   vector,
    output logic               ret,
    output logic [WIDTH-1:0]   epc_out,
    output logic [LW-1:0]      level,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic               overflow
);

    // src encoding: 0..NUM_IRQ-1 channels, NUM_IRQ ecall, NUM_IRQ+1 idle priority
    localparam int SW = $clog2(NUM_IRQ + 2);

    logic [NUM_IRQ-1:0] r_sync1, r_sync2, r_sync3;
    logic [NUM_IRQ-1:0] r_pending, r_in_service, r_mask;
    logic [LW-1:0]      r_level;
    logic               r_overflow;
    logic [WIDTH-1:0]   r_epc [NEST_DEPTH];
    logic [SW-1:0]      r_src [NEST_DEPTH];

    logic [NUM_IRQ-1:0] w_edge;
    logic               w_empty, w_full;
    logic [WIDTH-1:0]   w_top_epc;
    logic [SW-1:0]      w_top_src, w_cur_prio, w_cand, w_push_src;
    logic               w_cand_valid;
    logic [NUM_IRQ-1:0] w_cand_oh, w_top_oh;
    logic               w_go, w_uret_ok, w_do_ret, w_do_ecall, w_do_irq, w_ovf_set;
    logic [NUM_IRQ-1:0] w_pend_clr, w_is_clr, w_mask_next;

    assign w_edge  = r_sync2 & ~r_sync3;
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(NEST_DEPTH));

    always_comb begin
        w_top_epc = '0;
        w_top_src = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (int'(r_level) == i + 1) begin
                w_top_epc = r_epc[i];
                w_top_src = r_src[i];
            end
        end
    end

    assign w_cur_prio = w_empty ? SW'(NUM_IRQ + 1) : w_top_src;

    // Descending scan so the lowest eligible channel is the one left standing
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand       = '0;
        w_cand_oh    = '0;
        w_top_oh     = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (r_pending[k] && r_mask[k] && (k < int'(w_cur_prio))) begin
                w_cand_valid = 1'b1;
                w_cand       = SW'(k);
                w_cand_oh    = '0;
                w_cand_oh[k] = 1'b1;
            end
            if (w_top_src == SW'(k)) begin
                w_top_oh[k] = 1'b1;
            end
        end
    end

    assign w_go       = rst_n && !stall;
    assign w_uret_ok  = uret && !w_empty;
    assign w_do_ret   = w_go && w_uret_ok;
    assign w_do_ecall = w_go && !w_uret_ok && ecall && !w_full;
    assign w_ovf_set  = w_go && !w_uret_ok && ecall && w_full;
    assign w_do_irq   = w_go && !w_uret_ok && !ecall && w_cand_valid && !w_full;

    assign take       = w_do_ecall || w_do_irq;
    assign ret        = w_do_ret;
    assign vector     = w_do_irq ? VEC_BASE + WIDTH'(VEC_STRIDE) * WIDTH'(int'(w_cand) + 1)
                                 : VEC_BASE;
    assign w_push_src = w_do_irq ? w_cand : SW'(NUM_IRQ);
    assign w_pend_clr = w_do_irq ? w_cand_oh : '0;
    assign w_is_clr   = w_do_ret ? w_top_oh : '0;

    always_comb begin
        w_mask_next = r_mask;
        case (csr_op)
            2'b00:   w_mask_next = csr_wdata;
            2'b01:   w_mask_next = r_mask | csr_wdata;
            2'b10:   w_mask_next = r_mask & ~csr_wdata;
            default: w_mask_next = r_mask;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sync3      <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= '1;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                r_epc[i] <= '0;
                r_src[i] <= '0;
            end
        end else begin
            r_sync1      <= irq_in;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            // A fresh edge wins over the clear from a take on the same channel
            r_pending    <= (r_pending & ~w_pend_clr) | w_edge;
            r_in_service <= (r_in_service & ~w_is_clr) | w_pend_clr;
            if (csr_we) begin
                r_mask <= w_mask_next;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_do_ret) begin
                r_level <= r_level - 1'b1;
            end else if (take) begin
                r_level <= r_level + 1'b1;
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    if (int'(r_level) == i) begin
                        r_epc[i] <= epc_in;
                        r_src[i] <= w_push_src;
                    end
                end
            end
        end
    end

    assign csr_rdata  = r_mask;
    assign epc_out    = w_top_epc;
    assign level      = r_level;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign overflow   = r_overflow;

endmodule
